// File: rtl/gpo_pad_seq_if.sv
// rtl/gpo_pad_seq_if.sv - config request handshake between pad-config block and gpo_pad_seq
interface gpo_pad_seq_if;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [1:0] cfg_ds_i;
  logic       cfg_sr_i;
  logic       cfg_co_i;
  logic       cfg_odp_i;
  logic       cfg_odn_i;
  logic       cfg_oe_i;

  modport master (
    output cfg_valid_i, cfg_ds_i, cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_oe_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i, cfg_ds_i, cfg_sr_i, cfg_co_i, cfg_odp_i, cfg_odn_i, cfg_oe_i,
    output cfg_ready_o
  );
endinterface

// File: rtl/gpo_pad_seq.sv
// rtl/gpo_pad_seq.sv - glitch-free configuration sequencer for one GPO output pad
module gpo_pad_seq #(
  parameter int SETTLE_CYC = 4,
  parameter int BIAS_TMO   = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  gpo_pad_seq_if.slave  cfg,
  input  logic          do_i,
  input  logic          vbias_ok_i,
  input  logic          err_clr_i,
  output logic          pad_do_o,
  output logic [1:0]    pad_ds_o,
  output logic          pad_sr_o,
  output logic          pad_co_o,
  output logic          pad_oe_o,
  output logic          pad_odp_o,
  output logic          pad_odn_o,
  output logic          busy_o,
  output logic          err_bias_o
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_ON,
    ST_QUIESCE,
    ST_APPLY,
    ST_BIAS
  } state_t;

  typedef struct packed {
    logic [1:0] ds;
    logic       sr;
    logic       co;
    logic       odp;
    logic       odn;
    logic       oe;
  } pad_cfg_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] BIAS_LAST   = 16'(BIAS_TMO - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  pad_cfg_t    sh_q, sh_d, req;

  logic [1:0]  ds_d;
  logic        sr_d, co_d, odp_d, odn_d, oe_d;
  logic        ready_d, busy_d, err_d, err_set;
  logic        bias_loss, accept;

  assign req = '{ds: cfg.cfg_ds_i, sr: cfg.cfg_sr_i, co: cfg.cfg_co_i,
                 odp: cfg.cfg_odp_i, odn: cfg.cfg_odn_i, oe: cfg.cfg_oe_i};

  // next-state, shadow and pad-control decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ds_d    = pad_ds_o;
    sr_d    = pad_sr_o;
    co_d    = pad_co_o;
    odp_d   = pad_odp_o;
    odn_d   = pad_odn_o;
    oe_d    = pad_oe_o;
    err_set = 1'b0;

    // Losing bias while driving wins over a new request in the same cycle.
    bias_loss = (state_q == ST_ON) && (pad_ds_o != 2'b00) && !vbias_ok_i;
    accept    = cfg.cfg_valid_i && cfg.cfg_ready_o && !bias_loss;

    case (state_q)
      ST_OFF: begin
        if (accept) begin
          // OE is already low, so the new drive settings go straight to the pad.
          sh_d    = req;
          ds_d    = req.ds;
          sr_d    = req.sr;
          co_d    = req.co;
          odp_d   = req.odp;
          odn_d   = req.odn;
          oe_d    = 1'b0;
          state_d = ST_APPLY;
        end
      end
      ST_ON: begin
        if (bias_loss) begin
          oe_d    = 1'b0;
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_BIAS;
        end else if (accept) begin
          sh_d    = req;
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == SETTLE_LAST) begin
          ds_d    = sh_q.ds;
          sr_d    = sh_q.sr;
          co_d    = sh_q.co;
          odp_d   = sh_q.odp;
          odn_d   = sh_q.odn;
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_APPLY: begin
        if ((sh_q.ds != 2'b00) && !vbias_ok_i) begin
          cnt_d   = '0;
          state_d = ST_BIAS;
        end else begin
          oe_d    = sh_q.oe;
          state_d = sh_q.oe ? ST_ON : ST_OFF;
        end
      end
      ST_BIAS: begin
        if (vbias_ok_i) begin
          oe_d    = sh_q.oe;
          state_d = sh_q.oe ? ST_ON : ST_OFF;
        end else if (cnt_q == BIAS_LAST) begin
          // Give up on the bias: fall back to the weakest drive and flag it.
          ds_d    = 2'b00;
          err_set = 1'b1;
          oe_d    = sh_q.oe;
          state_d = sh_q.oe ? ST_ON : ST_OFF;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        oe_d    = 1'b0;
        state_d = ST_OFF;
      end
    endcase

    ready_d = (state_d == ST_OFF) || (state_d == ST_ON);
    busy_d  = !ready_d;
    err_d   = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_bias_o);
  end

  // state and registered outputs; reset aborts any sequence in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_OFF;
      cnt_q           <= '0;
      sh_q            <= '0;
      pad_do_o        <= 1'b0;
      pad_ds_o        <= 2'b00;
      pad_sr_o        <= 1'b0;
      pad_co_o        <= 1'b0;
      pad_oe_o        <= 1'b0;
      pad_odp_o       <= 1'b0;
      pad_odn_o       <= 1'b0;
      cfg.cfg_ready_o <= 1'b1;
      busy_o          <= 1'b0;
      err_bias_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sh_q            <= sh_d;
      pad_do_o        <= do_i;
      pad_ds_o        <= ds_d;
      pad_sr_o        <= sr_d;
      pad_co_o        <= co_d;
      pad_oe_o        <= oe_d;
      pad_odp_o       <= odp_d;
      pad_odn_o       <= odn_d;
      cfg.cfg_ready_o <= ready_d;
      busy_o          <= busy_d;
      err_bias_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_gpo_pad_seq.sv
// tb/tb_gpo_pad_seq.sv - scoreboard bench for gpo_pad_seq
module tb_gpo_pad_seq;

  localparam int K_OE = 0, K_DS = 1, K_SR = 2, K_CO = 3, K_ODP = 4, K_ODN = 5;
  localparam int K_READY = 6, K_BUSY = 7, K_ERR = 8;

  typedef struct {
    string name;
    int    at;
    int    kind;
    int    val;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       do_i;
  logic       vbias_ok_i;
  logic       err_clr_i;
  logic       pad_do_o, pad_sr_o, pad_co_o, pad_oe_o, pad_odp_o, pad_odn_o;
  logic [1:0] pad_ds_o;
  logic       busy_o, err_bias_o;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic do_exp = 1'b0;
  exp_t sb[$];

  gpo_pad_seq_if cfg_if ();

  gpo_pad_seq #(.SETTLE_CYC(4), .BIAS_TMO(64)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cfg        (cfg_if),
    .do_i       (do_i),
    .vbias_ok_i (vbias_ok_i),
    .err_clr_i  (err_clr_i),
    .pad_do_o   (pad_do_o),
    .pad_ds_o   (pad_ds_o),
    .pad_sr_o   (pad_sr_o),
    .pad_co_o   (pad_co_o),
    .pad_oe_o   (pad_oe_o),
    .pad_odp_o  (pad_odp_o),
    .pad_odn_o  (pad_odn_o),
    .busy_o     (busy_o),
    .err_bias_o (err_bias_o)
  );

  always #5 clk_i = ~clk_i;

  // edge counter and one-cycle-delay model of the data path
  always @(posedge clk_i) begin
    cyc++;
    do_exp = rst_i ? 1'b0 : do_i;
  end

  function automatic int get_val(int kind);
    case (kind)
      K_OE:    return int'(pad_oe_o);
      K_DS:    return int'(pad_ds_o);
      K_SR:    return int'(pad_sr_o);
      K_CO:    return int'(pad_co_o);
      K_ODP:   return int'(pad_odp_o);
      K_ODN:   return int'(pad_odn_o);
      K_READY: return int'(cfg_if.cfg_ready_o);
      K_BUSY:  return int'(busy_o);
      default: return int'(err_bias_o);
    endcase
  endfunction

  // monitor: data path every cycle, scoreboard entries due at this edge
  always @(negedge clk_i) begin
    int act;
    checks++;
    if (pad_do_o !== do_exp) begin
      errors++;
      $display("FAIL pad_do @%0d: got %b want %b", cyc, pad_do_o, do_exp);
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        checks++;
        act = get_val(sb[i].kind);
        if (sb[i].at < cyc) begin
          errors++;
          $display("FAIL %s: due at edge %0d, missed (now %0d)", sb[i].name, sb[i].at, cyc);
        end else if (act != sb[i].val) begin
          errors++;
          $display("FAIL %s @%0d: got %0d want %0d", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input string nm, input int at, input int kind, input int val);
    exp_t e;
    e.name = nm;
    e.at   = at;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_reset(input string nm, input int at);
    expect_at({nm, "_oe"},    at, K_OE,    0);
    expect_at({nm, "_ds"},    at, K_DS,    0);
    expect_at({nm, "_sr"},    at, K_SR,    0);
    expect_at({nm, "_co"},    at, K_CO,    0);
    expect_at({nm, "_odp"},   at, K_ODP,   0);
    expect_at({nm, "_odn"},   at, K_ODN,   0);
    expect_at({nm, "_ready"}, at, K_READY, 1);
    expect_at({nm, "_busy"},  at, K_BUSY,  0);
    expect_at({nm, "_err"},   at, K_ERR,   0);
  endtask

  // drives a request at a negedge; n is the edge that samples it
  task automatic send(input logic [1:0] ds, input logic sr, input logic co,
                      input logic odp, input logic odn, input logic oe, output int n);
    cfg_if.cfg_valid_i = 1'b1;
    cfg_if.cfg_ds_i    = ds;
    cfg_if.cfg_sr_i    = sr;
    cfg_if.cfg_co_i    = co;
    cfg_if.cfg_odp_i   = odp;
    cfg_if.cfg_odn_i   = odn;
    cfg_if.cfg_oe_i    = oe;
    n = cyc + 1;
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk_i);
  endtask

  // functional data toggles every cycle regardless of sequencing
  initial begin
    do_i = 1'b0;
    forever begin
      @(negedge clk_i);
      do_i = ~do_i;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    rst_i              = 1'b1;
    vbias_ok_i         = 1'b1;
    err_clr_i          = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ds_i    = 2'b00;
    cfg_if.cfg_sr_i    = 1'b0;
    cfg_if.cfg_co_i    = 1'b0;
    cfg_if.cfg_odp_i   = 1'b0;
    cfg_if.cfg_odn_i   = 1'b0;
    cfg_if.cfg_oe_i    = 1'b0;

    @(negedge clk_i);
    expect_reset("reset", cyc + 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // OFF -> ON, no bias needed
    send(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, n);
    expect_at("s1_ready_drop", n,     K_READY, 0);
    expect_at("s1_busy",       n,     K_BUSY,  1);
    expect_at("s1_sr",         n,     K_SR,    1);
    expect_at("s1_oe_apply",   n,     K_OE,    0);
    expect_at("s1_oe_on",      n + 1, K_OE,    1);
    expect_at("s1_busy_end",   n + 1, K_BUSY,  0);
    expect_at("s1_ready_back", n + 1, K_READY, 1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(2);

    // ON -> ON through quiesce, bias ok
    send(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    for (int k = 0; k < 5; k++) expect_at($sformatf("s2_oe_low%0d", k), n + k, K_OE, 0);
    expect_at("s2_ds_old",  n + 3, K_DS,   0);
    expect_at("s2_ds_new",  n + 4, K_DS,   2);
    expect_at("s2_sr_new",  n + 4, K_SR,   0);
    expect_at("s2_busy",    n + 4, K_BUSY, 1);
    expect_at("s2_oe_high", n + 5, K_OE,   1);
    expect_at("s2_busy_end", n + 5, K_BUSY, 0);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(6);

    // bias loss in ON with a same-cycle request that must be refused
    vbias_ok_i = 1'b0;
    send(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    expect_at("s3_oe_off",   n,     K_OE,    0);
    expect_at("s3_err",      n,     K_ERR,   1);
    expect_at("s3_ready",    n,     K_READY, 0);
    expect_at("s3_busy",     n,     K_BUSY,  1);
    expect_at("s3_oe_wait",  n + 2, K_OE,    0);
    expect_at("s3_oe_back",  n + 3, K_OE,    1);
    expect_at("s3_ds_kept",  n + 3, K_DS,    2);
    expect_at("s3_ready_on", n + 3, K_READY, 1);
    expect_at("s3_err_held", n + 3, K_ERR,   1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(2);
    vbias_ok_i = 1'b1;
    step(2);

    err_clr_i = 1'b1;
    m = cyc + 1;
    expect_at("s3_err_clr", m, K_ERR, 0);
    @(negedge clk_i);
    err_clr_i = 1'b0;
    step(1);

    // bias never arrives: timeout after 64 bias cycles
    send(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    expect_at("s4_ds_applied", n + 4,  K_DS,   3);
    expect_at("s4_ds_pre",     n + 68, K_DS,   3);
    expect_at("s4_oe_pre",     n + 68, K_OE,   0);
    expect_at("s4_err_pre",    n + 68, K_ERR,  0);
    expect_at("s4_busy_pre",   n + 68, K_BUSY, 1);
    expect_at("s4_ds_forced",  n + 69, K_DS,   0);
    expect_at("s4_err_set",    n + 69, K_ERR,  1);
    expect_at("s4_oe_on",      n + 69, K_OE,   1);
    expect_at("s4_busy_end",   n + 69, K_BUSY, 0);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    vbias_ok_i = 1'b0;
    step(70);
    err_clr_i = 1'b1;
    m = cyc + 1;
    expect_at("s4_err_clr", m, K_ERR, 0);
    @(negedge clk_i);
    err_clr_i = 1'b0;

    // set beats clear, then reset while in BIAS
    vbias_ok_i = 1'b1;
    send(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    expect_at("s5_ds", n + 4, K_DS, 1);
    expect_at("s5_oe", n + 5, K_OE, 1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(6);
    vbias_ok_i = 1'b0;
    err_clr_i  = 1'b1;
    m = cyc + 1;
    expect_at("s5_err_set_wins", m, K_ERR,  1);
    expect_at("s5_oe_off",       m, K_OE,   0);
    expect_at("s5_busy",         m, K_BUSY, 1);
    @(negedge clk_i);
    err_clr_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    expect_reset("s5_rst_bias", cyc + 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    vbias_ok_i = 1'b1;

    // reset while in QUIESCE
    send(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
    expect_at("s6_oe_on", n + 1, K_OE, 1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(2);
    send(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, n);
    expect_at("s6_oe_q",   n, K_OE,   0);
    expect_at("s6_busy_q", n, K_BUSY, 1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    expect_reset("s6_rst_quiesce", cyc + 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ON then an oe=0 request ends in OFF after the full sequence
    send(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, n);
    expect_at("s7_co",  n,     K_CO,  1);
    expect_at("s7_odp", n,     K_ODP, 1);
    expect_at("s7_oe",  n + 1, K_OE,  1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(2);
    send(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, n);
    expect_at("s7_oe_q",      n,     K_OE,    0);
    expect_at("s7_odn_old",   n + 3, K_ODN,   0);
    expect_at("s7_odn_new",   n + 4, K_ODN,   1);
    expect_at("s7_co_new",    n + 4, K_CO,    0);
    expect_at("s7_odp_new",   n + 4, K_ODP,   0);
    expect_at("s7_busy_app",  n + 4, K_BUSY,  1);
    expect_at("s7_oe_off",    n + 5, K_OE,    0);
    expect_at("s7_busy_end",  n + 5, K_BUSY,  0);
    expect_at("s7_ready_off", n + 5, K_READY, 1);
    @(negedge clk_i);
    cfg_if.cfg_valid_i = 1'b0;
    step(7);

    for (int g = 0; g < 100 && sb.size() > 0; g++) @(negedge clk_i);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never sampled (due at edge %0d)", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
